// File: rtl/pipe_ifid_stage.sv
// IF/ID pipeline register with a load-use hazard unit, a branch flush and a
// saturating counter of the cycles in which the PC was frozen.
module pipe_ifid_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [31:0]      if_pc,
    input  logic [31:0]      if_inst,
    input  logic             ex_wreg,
    input  logic             ex_m2reg,
    input  logic [4:0]       ex_rn,
    input  logic             hold,
    input  logic             flush,
    output logic             IFwip,
    output logic             id_stall,
    output logic [31:0]      id_inst,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_pc4,
    output logic             id_valid,
    output logic [CNT_W-1:0] stall_count
);

    // j, jal, lui and the constant shifts take no rs source operand.
    function automatic logic f_uses_rs(input logic [5:0] op, input logic [5:0] funct);
        logic r;
        case (op)
            6'b000010, 6'b000011, 6'b001111: r = 1'b0;
            6'b000000: r = !(funct == 6'b000000 || funct == 6'b000010 || funct == 6'b000011);
            default:   r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic f_uses_rt(input logic [5:0] op);
        logic r;
        case (op)
            6'b000000, 6'b000100, 6'b000101, 6'b101011: r = 1'b1;
            default:                                    r = 1'b0;
        endcase
        return r;
    endfunction

    logic [31:0]      id_inst_q, id_inst_d;
    logic [31:0]      id_pc_q, id_pc_d;
    logic             id_valid_q, id_valid_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             hazard_s, eflush_s, ifwip_s;
    logic             rs_hit_s, rt_hit_s;

    // Load-use hazard against EX; a bubble or a $0 destination never matches.
    always_comb begin
        rs_hit_s = f_uses_rs(id_inst_q[31:26], id_inst_q[5:0]) && (id_inst_q[25:21] == ex_rn);
        rt_hit_s = f_uses_rt(id_inst_q[31:26]) && (id_inst_q[20:16] == ex_rn);
        hazard_s = id_valid_q && ex_wreg && ex_m2reg && (ex_rn != 5'd0) && (rs_hit_s || rt_hit_s);
        eflush_s = flush && !hazard_s;
        ifwip_s  = !(hazard_s || hold);
    end

    // Next-state for the IF/ID register and the stall counter.
    always_comb begin
        id_inst_d     = id_inst_q;
        id_pc_d       = id_pc_q;
        id_valid_d    = id_valid_q;
        stall_count_d = stall_count_q;
        if (!ifwip_s) begin
            if (stall_count_q != {CNT_W{1'b1}}) begin
                stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_count_d = stall_count_q;
            end
        end else if (eflush_s) begin
            id_inst_d  = 32'h0000_0000;
            id_pc_d    = if_pc;
            id_valid_d = 1'b0;
        end else begin
            id_inst_d  = if_inst;
            id_pc_d    = if_pc;
            id_valid_d = 1'b1;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            id_inst_q     <= 32'h0000_0000;
            id_pc_q       <= RESET_PC;
            id_valid_q    <= 1'b0;
            stall_count_q <= {CNT_W{1'b0}};
        end else begin
            id_inst_q     <= id_inst_d;
            id_pc_q       <= id_pc_d;
            id_valid_q    <= id_valid_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign IFwip       = ifwip_s;
    assign id_stall    = hazard_s;
    assign id_inst     = id_inst_q;
    assign id_pc       = id_pc_q;
    assign id_pc4      = id_pc_q + 32'd4;
    assign id_valid    = id_valid_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_ifid_stage.sv
// Directed bench for pipe_ifid_stage with hand-computed expectations.
module tb_pipe_ifid_stage;

    logic        clk, clrn;
    logic [31:0] if_pc, if_inst;
    logic        ex_wreg, ex_m2reg, hold, flush;
    logic [4:0]  ex_rn;
    logic        IFwip, id_stall, id_valid;
    logic [31:0] id_inst, id_pc, id_pc4;
    logic [15:0] stall_count;

    int compared = 0;
    int mismatched = 0;

    localparam logic [31:0] ADD_8_9_3 = 32'h0123_4020;
    localparam logic [31:0] LUI_3     = 32'h3C03_1234;

    pipe_ifid_stage #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
        .clk(clk), .clrn(clrn), .if_pc(if_pc), .if_inst(if_inst),
        .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rn(ex_rn),
        .hold(hold), .flush(flush), .IFwip(IFwip), .id_stall(id_stall),
        .id_inst(id_inst), .id_pc(id_pc), .id_pc4(id_pc4),
        .id_valid(id_valid), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clrn = 1'b0; if_pc = 32'h0; if_inst = 32'h0;
        ex_wreg = 1'b0; ex_m2reg = 1'b0; ex_rn = 5'd0; hold = 1'b0; flush = 1'b0;
        #3;
        check("rst_inst", id_inst, 32'h0);
        check("rst_pc", id_pc, 32'h0);
        check("rst_valid", {31'h0, id_valid}, 32'h0);
        check("rst_cnt", {16'h0, stall_count}, 32'h0);
        check("rst_ifwip", {31'h0, IFwip}, 32'h1);

        // Straight-line capture.
        tick();
        clrn = 1'b1; if_pc = 32'h0000_0040; if_inst = ADD_8_9_3;
        tick();
        check("cap_pc", id_pc, 32'h40);
        check("cap_pc4", id_pc4, 32'h44);
        check("cap_inst", id_inst, ADD_8_9_3);
        check("cap_valid", {31'h0, id_valid}, 32'h1);

        // Load-use on rt ($3).
        ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rn = 5'd3;
        if_pc = 32'h44; if_inst = LUI_3;
        #1;
        check("lu_ifwip", {31'h0, IFwip}, 32'h0);
        check("lu_stall", {31'h0, id_stall}, 32'h1);
        ex_rn = 5'd9;
        #1;
        check("lu_rs_ifwip", {31'h0, IFwip}, 32'h0);
        ex_rn = 5'd3;
        tick();
        check("lu_hold_inst", id_inst, ADD_8_9_3);
        check("lu_hold_pc", id_pc, 32'h40);
        check("lu_cnt", {16'h0, stall_count}, 32'h1);
        ex_rn = 5'd8;
        #1;
        check("rd_nohaz", {31'h0, IFwip}, 32'h1);
        ex_rn = 5'd0;
        #1;
        check("rn0_ifwip", {31'h0, IFwip}, 32'h1);
        check("rn0_stall", {31'h0, id_stall}, 32'h0);
        tick();
        check("resume_inst", id_inst, LUI_3);
        check("resume_pc", id_pc, 32'h44);
        check("resume_cnt", {16'h0, stall_count}, 32'h1);

        // lui uses neither source register.
        ex_rn = 5'd3;
        #1;
        check("lui_nohaz", {31'h0, IFwip}, 32'h1);

        // Flush without hazard.
        flush = 1'b1; ex_rn = 5'd0; if_pc = 32'h80; if_inst = 32'hDEAD_BEEF;
        tick();
        check("fl_inst", id_inst, 32'h0);
        check("fl_valid", {31'h0, id_valid}, 32'h0);
        check("fl_pc", id_pc, 32'h80);
        flush = 1'b0; ex_rn = 5'd3;
        #1;
        check("bubble_nohaz", {31'h0, IFwip}, 32'h1);

        // Flush during hazard is ignored; hold plus hazard counts once.
        ex_rn = 5'd0; if_pc = 32'h90; if_inst = ADD_8_9_3;
        tick();
        ex_rn = 5'd3; flush = 1'b1; hold = 1'b1; if_pc = 32'h94; if_inst = 32'hDEAD_BEEF;
        tick();
        check("flh_inst", id_inst, ADD_8_9_3);
        check("flh_valid", {31'h0, id_valid}, 32'h1);
        check("flh_pc", id_pc, 32'h90);
        check("flh_cnt", {16'h0, stall_count}, 32'h2);
        flush = 1'b0; hold = 1'b0; ex_rn = 5'd0;

        // PC wrap.
        if_pc = 32'hFFFF_FFFC; if_inst = ADD_8_9_3;
        tick();
        check("wrap_pc", id_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", id_pc4, 32'h0);

        // Asynchronous reset during an active hazard.
        ex_rn = 5'd3;
        tick();
        check("pre_rst_cnt", {16'h0, stall_count}, 32'h3);
        #2;
        clrn = 1'b0;
        #1;
        check("mrst_inst", id_inst, 32'h0);
        check("mrst_pc", id_pc, 32'h0);
        check("mrst_valid", {31'h0, id_valid}, 32'h0);
        check("mrst_cnt", {16'h0, stall_count}, 32'h0);
        check("mrst_ifwip", {31'h0, IFwip}, 32'h1);
        tick();
        check("rst_held_inst", id_inst, 32'h0);
        clrn = 1'b1; ex_rn = 5'd0; if_pc = 32'h100; if_inst = LUI_3;
        tick();
        check("post_rst_inst", id_inst, LUI_3);

        // Saturation under a long external hold.
        hold = 1'b1; if_pc = 32'h200;
        for (int i = 0; i < 70000; i++) @(posedge clk);
        #1;
        check("sat_cnt", {16'h0, stall_count}, 32'h0000_FFFF);
        check("sat_pc", id_pc, 32'h100);
        for (int i = 0; i < 5; i++) @(posedge clk);
        #1;
        check("sat_stays", {16'h0, stall_count}, 32'h0000_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipe_ifid_stage.md
Name: pipe_ifid_stage

Overview:
- IF/ID pipeline register and load-use hazard unit, directly downstream of the instruction-fetch stage.
- Captures the fetched instruction and its PC each cycle and presents them to decode.
- Detects a load-use hazard against the instruction in EX. On a hazard it drives IFwip low to freeze the PC and inserts a bubble.
- Handles branch/jump flush and counts stall cycles for performance measurement.

Parameters:
- RESET_PC, 32'h0000_0000, value of id_pc after reset.
- CNT_W, 16, width of the stall cycle counter.

Ports:
- clk  in  1  rising-edge clock.
- clrn  in  1  asynchronous active-low reset.
- if_pc  in  32  PC of the instruction currently in IF.
- if_inst  in  32  instruction word from instruction ROM.
- ex_wreg  in  1  EX-stage instruction writes the register file.
- ex_m2reg  in  1  EX-stage instruction is a load.
- ex_rn  in  5  EX-stage destination register.
- hold  in  1  external freeze (e.g. memory not ready).
- flush  in  1  taken branch/jump resolved in ID this cycle.
- IFwip  out  1  PC write enable to the IF stage.
- id_stall  out  1  ID must inject a bubble into ID/EX (zero control signals).
- id_inst  out  32  registered instruction.
- id_pc  out  32  registered PC.
- id_pc4  out  32  id_pc + 4.
- id_valid  out  1  id_inst is a real instruction, not a bubble.
- stall_count  out  CNT_W  saturating count of cycles with IFwip=0.

Behaviour:
- Reset (clrn=0, asynchronous, any time including mid-stall):
  - id_inst=0, id_pc=RESET_PC, id_valid=0, stall_count=0.
  - Outputs stay at these values while clrn=0.
  - The first posedge after release captures if_inst/if_pc, provided IFwip=1.
- Field decode of id_inst:
  - op=[31:26], rs=[25:21], rt=[20:16], funct=[5:0].
- uses_rs is 1 except for:
  - op=000010 (j) or 000011 (jal);
  - op=001111 (lui);
  - op=000000 with funct in {000000, 000010, 000011} (sll, srl, sra).
- uses_rt is 1 for:
  - op=000000 (R-type);
  - op=000100 (beq) or 000101 (bne);
  - op=101011 (sw).
  - Otherwise uses_rt is 0.
- Hazard detection (combinational):
  - hazard = id_valid & ex_wreg & ex_m2reg & (ex_rn != 0) & ((uses_rs & rs == ex_rn) | (uses_rt & rt == ex_rn)).
  - id_stall = hazard.
  - IFwip = ~(hazard | hold).
- Effective flush: eflush = flush & ~hazard. A branch cannot resolve while its operands are pending, so flush is ignored during a hazard.
- Register update on posedge clk, in priority order:
  1. IFwip=0: id_inst, id_pc and id_valid hold. A single stall repeats the same ID instruction for exactly one extra cycle (load-use penalty = 1 cycle).
  2. IFwip=1 and eflush=1: id_inst <= 0 (nop), id_valid <= 0, id_pc <= if_pc.
  3. IFwip=1 and eflush=0: id_inst <= if_inst, id_pc <= if_pc, id_valid <= 1.
- id_pc4: combinational id_pc + 4, modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- stall_count:
  - Increments by 1 each posedge with IFwip=0.
  - Saturates at all-ones and never wraps.
  - Cleared only by reset.
- hold and hazard asserted together: both freeze. The cycle counts once.
- Bubble (id_valid=0): never raises a hazard, even if id_inst decodes as using a register.
- ex_rn=0: never a hazard ($0 is hardwired).

Test Plan:
- Reset check: clrn low mid-run with a stall active -> id_inst=0, id_pc=RESET_PC, id_valid=0, stall_count=0, IFwip=1 immediately, not waiting for clk.
- Straight-line capture:
  - Stimulus: if_pc=0x0000_0040, if_inst=0x0123_4020 (add $8,$9,$3), no hazard, one edge.
  - Response: id_pc=0x40, id_pc4=0x44, id_inst=0x0123_4020, id_valid=1.
- Load-use stall:
  - Stimulus: id_inst=add $8,$9,$3 with ex_wreg=1, ex_m2reg=1, ex_rn=3.
  - Response: IFwip=0 and id_stall=1 for one cycle; id_inst held; stall_count 0 -> 1.
  - Then ex_rn changes to 0 -> IFwip=1 and the next fetch is captured.
- No false hazard:
  - lui $3,0x1234 with ex_rn=3 load -> IFwip=1, since lui does not use rs/rt as a source.
  - Same result for any instruction when ex_rn=0.
  - Same result for a bubble (id_valid=0) when ex_rn matches.
- Flush:
  - flush=1, no hazard, if_pc=0x80 -> next cycle id_inst=0, id_valid=0, id_pc=0x80.
  - flush=1 during a hazard -> ignored; id_inst held.
- Boundaries:
  - id_pc=0xFFFF_FFFC -> id_pc4=0x0000_0000.
  - hold=1 for 70000 cycles -> stall_count saturates at 0xFFFF and stays there.
